// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding and sizing helper for the N-read / 1-write RAM.
`default_nettype none

package ram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  function automatic int depth_of(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_read_port.sv
// ram_read_port: one registered read port with optional write-to-read bypass.
`default_nettype none

module ram_read_port
  import ram_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic [WIDTH-1:0]      mem_data,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic             w_hit;
  logic [WIDTH-1:0] r_rdata;

  // Only the functional write port can be forwarded; debug writes never are.
  assign w_hit = (BYPASS != 0) && wen && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      r_rdata <= '0;
    end else if (w_hit) begin
      r_rdata <= wdata;
    end else begin
      r_rdata <= mem_data;
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/ram_nr1w.sv
// ram_nr1w: N-read / 1-write synchronous RAM with debug port and post-reset zero-fill sweep.
`default_nettype none

module ram_nr1w
  import ram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_RD         = 2,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0]      rdata,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        debug_addr,
  output logic [WIDTH-1:0]             debug_data,
  input  logic [ADDR_WIDTH-1:0]        debug_write_addr,
  input  logic [WIDTH-1:0]             debug_write_data,
  input  logic                         debug_write_en,
  output logic                         ready
);

  localparam int                    c_depth = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(c_depth - 1);

  logic [WIDTH-1:0]      r_mem [c_depth];
  ram_state_e            r_state;
  ram_state_e            w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ready;
  logic                  w_clear;
  logic                  w_run;
  logic                  w_collide;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == c_last) w_state_next = ST_RUN;
      ST_RUN:   w_state_next = ST_RUN;
      default:  w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_CLEAR) begin
        r_cnt <= r_cnt + ADDR_WIDTH'(1);
      end
      r_ready <= (r_state == ST_RUN) || (r_cnt == c_last);
    end
  end

  assign w_clear   = rst && (r_state == ST_CLEAR);
  assign w_run     = rst && (r_state == ST_RUN);
  assign w_collide = wen && (waddr == debug_write_addr);

  // The array itself is never reset; the sweep is the only way to zero it.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_mem[r_cnt] <= '0;
    end else if (w_run) begin
      if (debug_write_en && !w_collide) begin
        r_mem[debug_write_addr] <= debug_write_data;
      end
      if (wen) begin
        r_mem[waddr] <= wdata;
      end
    end
  end

  assign debug_data = r_mem[debug_addr];
  assign ready      = r_ready;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_raddr;
    assign w_raddr = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];

    ram_read_port #(
      .WIDTH      (WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BYPASS     (BYPASS)
    ) u_rd (
      .clk      (clk),
      .rst      (rst),
      .run      (r_state == ST_RUN),
      .raddr    (w_raddr),
      .mem_data (r_mem[w_raddr]),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .rdata    (rdata[gi*WIDTH +: WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_nr1w.sv
// tb_ram_nr1w: randomized and directed checks of two ram_nr1w configurations against a reference model.
`default_nettype none

module tb_ram_nr1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 32x32, 2 read ports, bypass, clear on reset
  logic        rst_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;
  logic [4:0]  waddr_a, dbg_addr_a, dwa_a;
  logic [31:0] wdata_a, dbg_data_a, dwd_a;
  logic        wen_a, dwe_a, ready_a;

  // DUT B: 8x8, 4 read ports, no bypass, no clear
  logic        rst_b;
  logic [11:0] raddr_b;
  logic [31:0] rdata_b;
  logic [2:0]  waddr_b, dbg_addr_b, dwa_b;
  logic [7:0]  wdata_b, dbg_data_b, dwd_b;
  logic        wen_b, dwe_b, ready_b;

  ram_nr1w #(.WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1), .CLEAR_ON_RESET(1)) u_dut_a (
    .clk(clk), .rst(rst_a), .raddr(raddr_a), .rdata(rdata_a),
    .waddr(waddr_a), .wdata(wdata_a), .wen(wen_a),
    .debug_addr(dbg_addr_a), .debug_data(dbg_data_a),
    .debug_write_addr(dwa_a), .debug_write_data(dwd_a), .debug_write_en(dwe_a),
    .ready(ready_a)
  );

  ram_nr1w #(.WIDTH(8), .ADDR_WIDTH(3), .NUM_RD(4), .BYPASS(0), .CLEAR_ON_RESET(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .raddr(raddr_b), .rdata(rdata_b),
    .waddr(waddr_b), .wdata(wdata_b), .wen(wen_b),
    .debug_addr(dbg_addr_b), .debug_data(dbg_data_b),
    .debug_write_addr(dwa_b), .debug_write_data(dwd_b), .debug_write_en(dwe_b),
    .ready(ready_b)
  );

  // Reference model state
  logic [31:0] ma [32];
  bit          ka [32];
  int          a_left = 32;
  int          a_idx  = 0;
  bit          ea_rdy;
  logic [31:0] ea_rd [2];
  bit          ea_rk [2];

  logic [7:0]  mb [8];
  bit          kb [8];
  bit          eb_rdy;
  logic [7:0]  eb_rd [4];
  bit          eb_rk [4];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_a();
    logic [4:0] ra;
    if (!rst_a) begin
      a_left = 32; a_idx = 0; ea_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin ea_rd[i] = '0; ea_rk[i] = 1'b1; end
    end else if (a_left > 0) begin
      ma[a_idx] = '0; ka[a_idx] = 1'b1;
      a_idx++; a_left--;
      ea_rdy = (a_left == 0);
      for (int i = 0; i < 2; i++) begin ea_rd[i] = '0; ea_rk[i] = 1'b1; end
    end else begin
      ea_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
        ra = raddr_a[i*5 +: 5];
        if (wen_a && waddr_a == ra) begin ea_rd[i] = wdata_a; ea_rk[i] = 1'b1; end
        else begin ea_rd[i] = ma[ra]; ea_rk[i] = ka[ra]; end
      end
      if (dwe_a && !(wen_a && dwa_a == waddr_a)) begin ma[dwa_a] = dwd_a; ka[dwa_a] = 1'b1; end
      if (wen_a) begin ma[waddr_a] = wdata_a; ka[waddr_a] = 1'b1; end
    end
  endtask

  task automatic model_b();
    logic [2:0] rb;
    if (!rst_b) begin
      eb_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin eb_rd[i] = '0; eb_rk[i] = 1'b1; end
    end else begin
      eb_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
        rb = raddr_b[i*3 +: 3];
        eb_rd[i] = mb[rb]; eb_rk[i] = kb[rb];
      end
      if (dwe_b && !(wen_b && dwa_b == waddr_b)) begin mb[dwa_b] = dwd_b; kb[dwa_b] = 1'b1; end
      if (wen_b) begin mb[waddr_b] = wdata_b; kb[waddr_b] = 1'b1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_a();
    model_b();
    #1;
    check("ready_a", {31'b0, ready_a}, {31'b0, ea_rdy});
    for (int i = 0; i < 2; i++)
      if (ea_rk[i]) check($sformatf("rdata_a[%0d]", i), rdata_a[i*32 +: 32], ea_rd[i]);
    if (ka[dbg_addr_a]) check("debug_a", dbg_data_a, ma[dbg_addr_a]);
    check("ready_b", {31'b0, ready_b}, {31'b0, eb_rdy});
    for (int i = 0; i < 4; i++)
      if (eb_rk[i]) check($sformatf("rdata_b[%0d]", i), {24'b0, rdata_b[i*8 +: 8]}, {24'b0, eb_rd[i]});
    if (kb[dbg_addr_b]) check("debug_b", {24'b0, dbg_data_b}, {24'b0, mb[dbg_addr_b]});
  endtask

  task automatic idle();
    wen_a = 0; dwe_a = 0; wen_b = 0; dwe_b = 0;
  endtask

  task automatic randomize_inputs(input bit collide);
    raddr_a = 10'($urandom); waddr_a = 5'($urandom); wdata_a = $urandom;
    wen_a = 1'($urandom); dwe_a = 1'($urandom); dwa_a = 5'($urandom); dwd_a = $urandom;
    dbg_addr_a = 5'($urandom);
    if (collide) begin waddr_a = raddr_a[4:0]; dwa_a = waddr_a; end
    raddr_b = 12'($urandom); waddr_b = 3'($urandom); wdata_b = 8'($urandom);
    wen_b = 1'($urandom); dwe_b = 1'($urandom); dwa_b = 3'($urandom); dwd_b = 8'($urandom);
    dbg_addr_b = 3'($urandom);
    if (collide) begin waddr_b = raddr_b[2:0]; dwa_b = waddr_b; end
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 32; i++) begin ka[i] = 1'b0; ma[i] = '0; end
    for (int i = 0; i < 8; i++)  begin kb[i] = 1'b0; mb[i] = '0; end
    rst_a = 0; rst_b = 0;
    raddr_a = '0; waddr_a = '0; wdata_a = '0; dbg_addr_a = '0; dwa_a = '0; dwd_a = '0;
    raddr_b = '0; waddr_b = '0; wdata_b = '0; dbg_addr_b = '0; dwa_b = '0; dwd_b = '0;
    idle();
    tick(); tick();

    // Sweep: functional and debug writes must be ignored while clearing
    rst_a = 1; rst_b = 1;
    lat = 0;
    while (!ready_a && lat < 40) begin
      wen_a = 1; waddr_a = 5'(lat); wdata_a = 32'hDEAD_0000 + lat;
      dwe_a = 1; dwa_a = 5'(lat + 1); dwd_a = 32'hBEEF;
      tick(); lat++;
    end
    check("sweep_len", lat, 32);
    idle();
    for (int i = 0; i < 32; i++) begin
      dbg_addr_a = 5'(i); #1;
      check("swept_zero", dbg_data_a, 32'h0);
    end

    // Debug preload then read back through both ports
    dwe_a = 1; dwa_a = 5'd4; dwd_a = 32'd3; tick();
    dwa_a = 5'd3; dwd_a = 32'd23; tick();
    idle(); raddr_a = {5'd4, 5'd3}; tick();
    check("preload_rd0", rdata_a[31:0], 32'd23);
    check("preload_rd1", rdata_a[63:32], 32'd3);

    // Bypass on port 0
    wen_a = 1; waddr_a = 5'd7; wdata_a = 32'hA5; raddr_a = {5'd1, 5'd7}; tick();
    check("bypass_a", rdata_a[31:0], 32'hA5);
    idle();

    // Functional vs debug write on same / different addresses
    wen_a = 1; waddr_a = 5'd5; wdata_a = 32'h1; dwe_a = 1; dwa_a = 5'd5; dwd_a = 32'h2; tick();
    idle(); dbg_addr_a = 5'd5; #1; check("collide_5", dbg_data_a, 32'h1);
    wen_a = 1; waddr_a = 5'd5; wdata_a = 32'h1; dwe_a = 1; dwa_a = 5'd6; dwd_a = 32'h2; tick();
    idle(); dbg_addr_a = 5'd6; #1; check("split_6", dbg_data_a, 32'h2);
    dbg_addr_a = 5'd5; #1; check("split_5", dbg_data_a, 32'h1);

    // B: no bypass returns the old word, new word one cycle later
    wen_b = 1; waddr_b = 3'd7; wdata_b = 8'h11; tick();
    wdata_b = 8'hA5; raddr_b = {3'd0, 3'd0, 3'd0, 3'd7}; tick();
    check("nobypass_old", {24'b0, rdata_b[7:0]}, 32'h11);
    idle(); tick();
    check("nobypass_new", {24'b0, rdata_b[7:0]}, 32'hA5);

    // B: four ports, distinct then identical addresses
    for (int i = 0; i < 8; i++) begin
      dwe_b = 1; dwa_b = 3'(i); dwd_b = 8'(8'h30 + i); tick();
    end
    idle();
    raddr_b = {3'd6, 3'd5, 3'd2, 3'd1}; tick();
    check("quad_p0", {24'b0, rdata_b[7:0]},   32'h31);
    check("quad_p3", {24'b0, rdata_b[31:24]}, 32'h36);
    raddr_b = {3'd4, 3'd4, 3'd4, 3'd4}; tick();
    check("quad_same", {24'b0, rdata_b[23:16]}, 32'h34);

    // Randomized traffic on both instances
    for (int n = 0; n < 400; n++) begin
      randomize_inputs($urandom_range(0, 3) == 0);
      tick();
    end
    idle();

    // A: reset mid-sweep restarts the sweep and discards contents
    wen_a = 1; waddr_a = 5'd20; wdata_a = 32'hFF; tick();
    idle(); dbg_addr_a = 5'd20; #1; check("pre_reset_20", dbg_data_a, 32'hFF);
    rst_a = 0; tick(); rst_a = 1;
    for (int i = 0; i < 10; i++) tick();
    rst_a = 0; tick(); rst_a = 1;
    lat = 0;
    while (!ready_a && lat < 40) begin tick(); lat++; end
    check("restart_len", lat, 32);
    dbg_addr_a = 5'd20; #1; check("post_reset_20", dbg_data_a, 32'h0);

    // B: reset retains contents, ready after one edge
    rst_b = 0; tick(); rst_b = 1; tick();
    check("b_ready_1edge", {31'b0, ready_b}, 32'h1);
    dbg_addr_b = 3'd4; #1; check("b_retained", {24'b0, dbg_data_b}, {24'b0, mb[4]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ram_nr1w.md
# ram_nr1w

Parametrised N-read / 1-write synchronous RAM with a side debug port and a hardware clear sequencer. It generalises the fixed two-read-port RAM that backs our HLS-generated kernels in testbenches to any width, depth and read-port count. It adds registered reads with selectable write-to-read bypass and a zero-fill sweep after reset. Kernels connect to the functional ports; benches preload and inspect memory through the debug port.

## Interface
- WIDTH, 32, data word width
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (≥1)
- BYPASS, 1, 1 = read of the address being written in the same cycle returns new data; 0 = returns old data
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset; 0 = contents retained across reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses, port i at slice i
- rdata  out  NUM_RD*WIDTH  registered read data, port i at slice i
- waddr  in  ADDR_WIDTH  functional write address
- wdata  in  WIDTH  functional write data
- wen  in  1  functional write enable
- debug_addr  in  ADDR_WIDTH  debug read address
- debug_data  out  WIDTH  combinational mem[debug_addr]
- debug_write_addr  in  ADDR_WIDTH  debug write address
- debug_write_data  in  WIDTH  debug write data
- debug_write_en  in  1  debug write enable
- ready  out  1  high once clear sweep done / memory usable

## Operation
- States: CLEAR, RUN. With rst=0: state ← CLEAR if CLEAR_ON_RESET else RUN; sweep counter ← 0; ready ← 0; all rdata ← 0. Memory array itself is not reset.
- CLEAR: each cycle writes 0 to mem[cnt], cnt ← cnt+1. After the cycle that writes DEPTH-1: state ← RUN, ready ← 1. wen and debug_write_en are ignored; rdata held at 0.
- CLEAR_ON_RESET=0: first edge with rst=1 sets ready ← 1 and state RUN.
- RUN, write: wen=1 → mem[waddr] ← wdata. debug_write_en=1 → mem[debug_write_addr] ← debug_write_data. Both at the same address in one cycle: functional write wins. Different addresses: both commit.
- RUN, read: rdata[i] ← mem[raddr[i]] each cycle, unconditionally. BYPASS=1 and wen=1 and waddr==raddr[i]: rdata[i] ← wdata. Debug writes are never bypassed. Every port bypasses independently. Several ports may read the same address.
- debug_data: purely combinational, valid in every state including reset. Shows array contents as of the last edge.
- Reset mid-sweep restarts the sweep at address 0. Reset in RUN re-enters CLEAR (if enabled), discarding contents.

## Timing
- Read latency 1 cycle: address at edge t → rdata valid after edge t+1. No read enable, no stall.
- Write latency 1 cycle: visible on debug_data and to non-bypassed reads after the committing edge.
- ready rises after exactly DEPTH rising edges with rst=1 (CLEAR_ON_RESET=1), or after 1 edge (=0).
- Reset values: rdata=0, ready=0; debug_data follows the array and is not a reset-controlled output.

## Structure
- Package ram_pkg: state enum (CLEAR, RUN); helper returning DEPTH from ADDR_WIDTH.
- Sub-module ram_read_port: one instance per port via generate. Holds the rdata register, the bypass compare/mux and the clear/reset zeroing.
- Top holds the array, write arbitration, sweep counter and FSM.

## Test plan
- Reset with CLEAR_ON_RESET=1, DEPTH=32: ready low for 32 edges after rst=1, high on the 32nd. debug_data at every address reads 0; wen during the sweep leaves the word 0.
- Debug preload mem[4]=3, mem[3]=23, then raddr0=3, raddr1=4 → next cycle rdata0=23, rdata1=3.
- BYPASS=1: wen with waddr=7, wdata=0xA5 while raddr0=7 → next cycle rdata0=0xA5. BYPASS=0, old value 0x11 → rdata0=0x11, then 0xA5 a cycle later.
- Simultaneous wen (addr 5, 0x1) and debug write (addr 5, 0x2) → debug_data at 5 reads 0x1. Same pair at addrs 5/6 → both stored.
- Reset asserted at sweep count 10 after a RUN write of 0xFF to addr 20 → sweep restarts, ready rises 32 edges after release, addr 20 reads 0.
- NUM_RD=4, WIDTH=8, ADDR_WIDTH=3: all four ports read distinct and identical addresses in one cycle → correct per-port data.
